// File: rtl/bypass_scoreboard_if.sv
// Bypass scoreboard bundle: Decode/Execute tags in, forwarding selects and
// interlocks out. Signal prefixes are from the scoreboard's point of view.
interface bypass_scoreboard_if #(
    parameter int REG_W  = 5,
    parameter int STAGES = 3,
    parameter int SEL_W  = $clog2(STAGES)
);
    logic             i_d_valid;
    logic             i_d_we;
    logic             i_d_is_load;
    logic             i_d_is_md;
    logic [REG_W-1:0] i_d_rd;
    logic [REG_W-1:0] i_d_rs_a;
    logic [REG_W-1:0] i_d_rs_b;
    logic [REG_W-1:0] i_x_rs_a;
    logic [REG_W-1:0] i_x_rs_b;
    logic             i_flush;
    logic [SEL_W-1:0] o_fwd_sel_a;
    logic [SEL_W-1:0] o_fwd_sel_b;
    logic             o_stall;
    logic             o_md_busy;

    // Pipeline side: drives Decode/Execute tags, consumes selects and stall.
    modport master (
        output i_d_valid, i_d_we, i_d_is_load, i_d_is_md, i_d_rd,
               i_d_rs_a, i_d_rs_b, i_x_rs_a, i_x_rs_b, i_flush,
        input  o_fwd_sel_a, o_fwd_sel_b, o_stall, o_md_busy
    );

    // Scoreboard side.
    modport slave (
        input  i_d_valid, i_d_we, i_d_is_load, i_d_is_md, i_d_rd,
               i_d_rs_a, i_d_rs_b, i_x_rs_a, i_x_rs_b, i_flush,
        output o_fwd_sel_a, o_fwd_sel_b, o_stall, o_md_busy
    );
endinterface

// File: rtl/bypass_scoreboard.sv
// Bypass scoreboard: shadow pipeline of destination tags for every stage after
// Decode, youngest-wins forwarding selects for both Execute operands and a
// load-use stall for Decode.
// Optional mult/div interlock: define MULTDIV_INTERLOCK_EN to enable it.
module bypass_scoreboard #(
    parameter int REG_W      = 5,
    parameter int STAGES     = 3,
    parameter int SEL_W      = $clog2(STAGES),
    parameter int MD_LATENCY = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    bypass_scoreboard_if.slave bus
);

    // Reject parameter sets the select encoding and counter cannot represent.
    if ((STAGES < 2) || (STAGES > 8) || (MD_LATENCY < 1)) begin : g_param_check
        $error("bypass_scoreboard: STAGES must be 2..8 and MD_LATENCY >= 1");
    end

    typedef struct packed {
        logic             valid;
        logic             we;
        logic             is_load;
        logic [REG_W-1:0] rd;
    } entry_t;

    entry_t           r_entry [STAGES];
    entry_t           w_entry_in;
    logic [STAGES-1:0] w_live;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_stall_lu;
    logic             w_stall_md;
    logic             w_md_busy;
    logic             w_stall;

    // Tag entering Execute: a bubble whenever Decode is held or killed.
    always_comb begin
        w_entry_in = '0;
        if (!bus.i_flush && !w_stall) begin
            w_entry_in.valid   = bus.i_d_valid;
            w_entry_in.we      = bus.i_d_we;
            w_entry_in.is_load = bus.i_d_is_load;
            w_entry_in.rd      = bus.i_d_rd;
        end
    end

    // Shadow tag pipeline advancing in lockstep with the datapath latches.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < STAGES; k++) begin
                r_entry[k] <= '0;
            end
        end else begin
            r_entry[0] <= w_entry_in;
            for (int k = 1; k < STAGES; k++) begin
                r_entry[k] <= r_entry[k-1];
            end
        end
    end

    // A stage is a forwarding source only if it really writes a nonzero register.
    always_comb begin
        w_live = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_live[k] = r_entry[k].valid & r_entry[k].we & (r_entry[k].rd != '0);
        end
    end

    // Youngest-wins select: scan oldest to youngest so the smallest k lands last.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (w_live[k] && (r_entry[k].rd == bus.i_x_rs_a)) begin
                w_sel_a = SEL_W'(k);
            end
            if (w_live[k] && (r_entry[k].rd == bus.i_x_rs_b)) begin
                w_sel_b = SEL_W'(k);
            end
        end
    end

    assign w_stall_lu = bus.i_d_valid & w_live[0] & r_entry[0].is_load &
                        ((r_entry[0].rd == bus.i_d_rs_a) |
                         (r_entry[0].rd == bus.i_d_rs_b));

`ifdef MULTDIV_INTERLOCK_EN
    localparam int MD_CNT_W = $clog2(MD_LATENCY + 1);

    logic [MD_CNT_W-1:0] r_md_cnt;
    logic [REG_W-1:0]    r_md_rd;

    assign w_md_busy  = (r_md_cnt != '0);
    assign w_stall_md = (bus.i_d_valid & w_md_busy & (r_md_rd != '0) &
                         ((bus.i_d_rs_a == r_md_rd) |
                          (bus.i_d_rs_b == r_md_rd) |
                          (bus.i_d_we & (bus.i_d_rd == r_md_rd)))) |
                        (bus.i_d_is_md & w_md_busy);

    // Mult/div busy down-counter; a flush does not cancel an in-flight op.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_md_cnt <= '0;
            r_md_rd  <= '0;
        end else if (!bus.i_flush && !w_stall && bus.i_d_valid && bus.i_d_is_md) begin
            r_md_cnt <= MD_CNT_W'(MD_LATENCY);
            r_md_rd  <= bus.i_d_rd;
        end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end
`else
    assign w_md_busy  = 1'b0;
    assign w_stall_md = 1'b0;
`endif

    // The stall output is not masked by flush; flush only wins at the latch.
    assign w_stall         = w_stall_lu | w_stall_md;
    assign bus.o_stall     = w_stall;
    assign bus.o_md_busy   = w_md_busy;
    assign bus.o_fwd_sel_a = w_sel_a;
    assign bus.o_fwd_sel_b = w_sel_b;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard (STAGES = 3, MD_LATENCY = 4).
module tb_bypass_scoreboard;
    localparam int REG_W  = 5;
    localparam int STAGES = 3;
    localparam int SEL_W  = 2;
    localparam int NVEC   = 25;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    bypass_scoreboard_if #(.REG_W(REG_W), .STAGES(STAGES), .SEL_W(SEL_W)) bus ();

    bypass_scoreboard #(
        .REG_W(REG_W), .STAGES(STAGES), .SEL_W(SEL_W), .MD_LATENCY(4)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );

    typedef struct {
        logic       v, we, ld;
        logic [4:0] rd, rs_a, rs_b, x_a, x_b;
        logic       fl;
        int         sa, sb, st;
    } vec_t;

    vec_t tbl [NVEC];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic v, logic we, logic ld, logic [4:0] rd,
                                logic [4:0] a, logic [4:0] b, logic [4:0] xa,
                                logic [4:0] xb, logic fl, int sa, int sb, int st);
        vec_t r;
        r.v = v; r.we = we; r.ld = ld; r.rd = rd; r.rs_a = a; r.rs_b = b;
        r.x_a = xa; r.x_b = xb; r.fl = fl; r.sa = sa; r.sb = sb; r.st = st;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_dec(input logic v, input logic we, input logic ld, input logic md,
                           input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        bus.i_d_valid   = v;
        bus.i_d_we      = we;
        bus.i_d_is_load = ld;
        bus.i_d_is_md   = md;
        bus.i_d_rd      = rd;
        bus.i_d_rs_a    = a;
        bus.i_d_rs_b    = b;
    endtask

    task automatic set_x(input logic [4:0] a, input logic [4:0] b);
        bus.i_x_rs_a = a;
        bus.i_x_rs_b = b;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_dec(0, 0, 0, 0, 0, 0, 0);
            set_x(0, 0);
            bus.i_flush = 1'b0;
        end
    endtask

    initial begin
        //        v we ld rd  a  b  xa xb fl sa sb st
        tbl[0]  = mk(1, 1, 0, 5,  1, 2,  5, 5,  0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 7,  5, 0,  5, 5,  0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 7,  0, 0,  5, 7,  0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0,  0, 0,  5, 7,  0, 2, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0,  0, 0,  5, 7,  0, 0, 1, 0);
        tbl[5]  = mk(1, 1, 1, 3,  0, 0,  0, 7,  0, 0, 2, 0);
        tbl[6]  = mk(1, 1, 0, 8,  3, 0,  0, 0,  0, 0, 0, 1);
        tbl[7]  = mk(1, 1, 0, 8,  3, 0,  3, 0,  0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,  0, 0,  3, 8,  0, 2, 0, 0);
        tbl[9]  = mk(1, 1, 1, 0,  0, 0,  8, 0,  0, 1, 0, 0);
        tbl[10] = mk(1, 1, 0, 9,  0, 0,  0, 8,  0, 0, 2, 0);
        tbl[11] = mk(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0);
        tbl[12] = mk(1, 1, 1, 4,  0, 0,  9, 0,  0, 1, 0, 0);
        tbl[13] = mk(1, 1, 0, 6,  1, 4,  9, 9,  1, 2, 2, 1);
        tbl[14] = mk(0, 0, 0, 0,  0, 0,  6, 4,  0, 0, 1, 0);
        tbl[15] = mk(0, 1, 0, 5,  0, 0,  4, 6,  0, 2, 0, 0);
        tbl[16] = mk(0, 0, 0, 0,  0, 0,  5, 5,  0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0,  0, 0,  5, 5,  0, 0, 0, 0);
        tbl[18] = mk(1, 0, 0, 2,  0, 0,  5, 0,  0, 0, 0, 0);
        tbl[19] = mk(1, 1, 1, 10, 2, 0,  0, 0,  0, 0, 0, 0);
        tbl[20] = mk(1, 1, 0, 11, 1, 10, 2, 2,  0, 0, 0, 1);
        tbl[21] = mk(1, 1, 0, 11, 1, 10, 10, 2, 0, 1, 0, 0);
        tbl[22] = mk(1, 1, 1, 12, 0, 0,  11, 10, 0, 0, 2, 0);
        tbl[23] = mk(0, 0, 0, 0,  12, 0, 11, 12, 0, 1, 0, 0);
        tbl[24] = mk(0, 0, 0, 0,  0, 0,  12, 11, 0, 1, 2, 0);

        rst = 1'b1;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_x(0, 0);
        bus.i_flush = 1'b0;
        #2;
        check("reset sel_a", int'(bus.o_fwd_sel_a), 0);
        check("reset sel_b", int'(bus.o_fwd_sel_b), 0);
        check("reset stall", int'(bus.o_stall), 0);
        check("reset md_busy", int'(bus.o_md_busy), 0);
        #10;
        rst = 1'b0;

        // Table: inputs held for one cycle, outputs sampled mid-cycle.
        for (int i = 0; i < NVEC; i++) begin
            next_cycle();
            set_dec(tbl[i].v, tbl[i].we, tbl[i].ld, 1'b0, tbl[i].rd, tbl[i].rs_a, tbl[i].rs_b);
            set_x(tbl[i].x_a, tbl[i].x_b);
            bus.i_flush = tbl[i].fl;
            @(negedge clk);
            check($sformatf("vec%0d sel_a", i), int'(bus.o_fwd_sel_a), tbl[i].sa);
            check($sformatf("vec%0d sel_b", i), int'(bus.o_fwd_sel_b), tbl[i].sb);
            check($sformatf("vec%0d stall", i), int'(bus.o_stall), tbl[i].st);
        end

        // Asynchronous reset mid-cycle with live forwarding and a pending stall.
        drain();
        next_cycle();
        set_dec(1, 1, 0, 0, 5, 0, 0);
        next_cycle();
        set_dec(1, 1, 1, 0, 3, 0, 0);
        next_cycle();
        set_dec(1, 1, 0, 0, 6, 3, 0);
        set_x(5, 0);
        @(negedge clk);
        check("prereset stall", int'(bus.o_stall), 1);
        check("prereset sel_a", int'(bus.o_fwd_sel_a), 1);
        #2;
        rst = 1'b1;
        bus.i_flush = 1'b1;
        #1;
        check("async rst sel_a", int'(bus.o_fwd_sel_a), 0);
        check("async rst stall", int'(bus.o_stall), 0);
        @(posedge clk);
        #2;
        check("rst+flush sel_a", int'(bus.o_fwd_sel_a), 0);
        rst = 1'b0;
        bus.i_flush = 1'b0;
        set_x(5, 3);
        @(negedge clk);
        check("postrst stall", int'(bus.o_stall), 0);
        check("postrst sel_a", int'(bus.o_fwd_sel_a), 0);
        check("postrst sel_b", int'(bus.o_fwd_sel_b), 0);
        next_cycle();
        set_dec(0, 0, 0, 0, 0, 0, 0);
        set_x(6, 5);
        @(negedge clk);
        check("postrst e0 sel_a", int'(bus.o_fwd_sel_a), 0);
        next_cycle();
        set_x(6, 5);
        @(negedge clk);
        check("postrst fwd sel_a", int'(bus.o_fwd_sel_a), 1);
        check("postrst fwd sel_b", int'(bus.o_fwd_sel_b), 0);

        // Mult/div interlock.
        drain();
`ifdef MULTDIV_INTERLOCK_EN
        next_cycle();
        set_dec(1, 1, 0, 1, 9, 0, 0);
        @(negedge clk);
        check("md issue busy", int'(bus.o_md_busy), 0);
        check("md issue stall", int'(bus.o_stall), 0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_dec(1, 1, 0, 0, 1, 9, 0);
            @(negedge clk);
            check($sformatf("md wait%0d stall", i), int'(bus.o_stall), 1);
            check($sformatf("md wait%0d busy", i), int'(bus.o_md_busy), 1);
        end
        next_cycle();
        @(negedge clk);
        check("md done stall", int'(bus.o_stall), 0);
        check("md done busy", int'(bus.o_md_busy), 0);
        next_cycle();
        set_dec(1, 1, 0, 1, 13, 0, 0);
        next_cycle();
        set_dec(1, 1, 0, 1, 14, 0, 0);
        @(negedge clk);
        check("md second stall", int'(bus.o_stall), 1);
        check("md second busy", int'(bus.o_md_busy), 1);
`else
        next_cycle();
        set_dec(1, 1, 0, 1, 9, 0, 0);
        @(negedge clk);
        check("nomd issue busy", int'(bus.o_md_busy), 0);
        next_cycle();
        set_dec(1, 1, 0, 0, 1, 9, 0);
        @(negedge clk);
        check("nomd use stall", int'(bus.o_stall), 0);
        check("nomd use busy", int'(bus.o_md_busy), 0);
        next_cycle();
        set_dec(1, 1, 0, 1, 14, 0, 0);
        @(negedge clk);
        check("nomd second stall", int'(bus.o_stall), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bypass_scoreboard.md
Name: bypass_scoreboard

Overview:
- Parametrised successor to the per-operand bypass select logic of the 5-stage processor pipeline.
- Keeps a registered shadow pipeline of destination tags (valid, rd, we, is_load) for every post-decode stage: Execute, Memory, Writeback and any extra stages.
- Produces youngest-wins forwarding selects for both Execute-stage operands and a load-use stall request for Decode.
- Sits beside the pipeline latches; advances in lockstep with them.

Parameters:
- REG_W, 5, register index width.
- STAGES, 3, number of tracked stages after Decode (index 0 = Execute, STAGES-1 = Writeback); legal range 2..8.
- SEL_W, $clog2(STAGES), width of each forwarding select.
- MD_LATENCY, 32, cycles a mult/div result is unavailable (used only with the optional feature).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all tag entries.
- d_valid  in  1  Decode holds a real instruction.
- d_we  in  1  Decode instruction writes a register.
- d_is_load  in  1  Decode instruction is lw.
- d_is_md  in  1  Decode instruction is mul/div.
- d_rd  in  REG_W  destination, already resolved by Decode (rstatus = 30 included).
- d_rs_a, d_rs_b  in  REG_W  Decode source operands, used for the stall check.
- x_rs_a, x_rs_b  in  REG_W  Execute source operands, used for forwarding.
- flush  in  1  taken branch/jump; kills Decode and Execute.
- fwd_sel_a, fwd_sel_b  out  SEL_W  0 = regfile; k = forward from stage k (1..STAGES-1).
- stall  out  1  hold PC and F/D latch; insert bubble into Execute.
- md_busy  out  1  mult/div interlock active (constant 0 without the optional feature).

Behaviour:
- State: entry[0..STAGES-1] of {valid, we, is_load, rd}. Reset: all valid=0; fwd_sel_a/b=0, stall=0, md_busy=0 as soon as reset asserts.
- Each rising clock edge, in priority order:
  - flush: entry[0] <= bubble; entry[k] <= entry[k-1] for k >= 1.
  - else stall: entry[0] <= bubble; shift as above.
  - else: entry[0] <= {d_valid, d_we, d_is_load, d_rd}; shift.
- "Bubble" means valid=0 and all other fields 0.
- The oldest entry drops off; the register file write happens that cycle.
- Live(k) = entry[k].valid & entry[k].we & (entry[k].rd != 0).
- Forwarding (combinational from state and x_rs_*):
  - fwd_sel_a = smallest k in 1..STAGES-1 with Live(k) & entry[k].rd == x_rs_a; 0 if none.
  - fwd_sel_b uses x_rs_b in the same way.
  - Register 0 never forwards.
  - A match in stage k with entry[k].is_load and k == 1 is still selected; the data path supplies load data from Memory.
- Load-use stall: stall = d_valid & Live(0) & entry[0].is_load & (entry[0].rd == d_rs_a | entry[0].rd == d_rs_b).
  - Stall lasts exactly 1 cycle per hazard.
  - After that cycle the load sits in entry[1] and forwards through fwd_sel = 1.
- flush overrides stall on the same edge (bubble inserted; no double bubble). The stall output itself is not masked by flush.
- Simultaneous flush and reset: reset wins.
- Reset mid-stream clears every entry; no forwarding selects survive.
- Tag comparison is exact REG_W-bit equality; no X-propagation handling is required.

Optional Feature:
- Macro: MULTDIV_INTERLOCK_EN.
- Defined:
  - md_cnt register (width $clog2(MD_LATENCY+1)) and md_rd register, both reset to 0.
  - On a non-stalled, non-flushed edge with d_valid & d_is_md: md_cnt <= MD_LATENCY, md_rd <= d_rd.
  - Otherwise md_cnt decrements when nonzero, saturating at 0.
  - md_busy = (md_cnt != 0).
  - stall additionally asserts when:
    - d_valid & md_busy & md_rd != 0 & (d_rs_a == md_rd | d_rs_b == md_rd | (d_we & d_rd == md_rd)), or
    - d_is_md & md_busy (no second mul/div while one is in flight).
  - flush does not cancel an in-flight mul/div.
- Undefined: no md_* state; md_busy tied 0; stall is load-use only.

Test Plan:
1. Reset asserted asynchronously mid-cycle -> fwd_sel_a = fwd_sel_b = 0 and stall = 0 immediately; all entries invalid on the next edge.
2. Issue add r5; next cycle x_rs_a = 5 -> fwd_sel_a = 1. One cycle later -> fwd_sel_a = 2. After that -> 0.
3. Two writers to r7 in consecutive cycles (older in stage 2, younger in stage 1), x_rs_b = 7 -> fwd_sel_b = 1 (youngest wins).
4. lw r3 followed by add using rs_a = 3 -> stall = 1 for exactly 1 cycle, entry[0] is a bubble, then fwd_sel_a = 1. Same sequence with rd = 0 -> stall = 0 and no forwarding.
5. Load-use hazard with flush = 1 on the same edge -> a single bubble enters entry[0]. Next cycle stall = 0 and no tags from the flushed instruction appear.
6. MULTDIV_INTERLOCK_EN, MD_LATENCY = 4: mul r9, then an add reading r9 -> stall held for 4 cycles while md_busy = 1. A second mul issued meanwhile is also stalled. Undefined build -> md_busy = 0 and no stall.
